// File: rtl/w_io_bank.sv
`default_nettype none
// w_io_bank: west-edge IO bank. Per-channel output/tristate/input registering selected by a
// frame-loaded config register; the column frame bus is forwarded, optionally pipelined.
module w_io_bank #(
  parameter int NUM_IO          = 2,
  parameter int C_BITS          = 4,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int PIPE_FRAME      = 0
) (
  input  logic                         UserCLK,
  input  logic                         UserRST,
  output logic                         UserCLKo,
  input  logic [NUM_IO-1:0]            I,
  input  logic [NUM_IO-1:0]            T,
  output logic [NUM_IO-1:0]            O,
  output logic [NUM_IO-1:0]            Q,
  output logic [NUM_IO-1:0]            I_top,
  output logic [NUM_IO-1:0]            T_top,
  input  logic [NUM_IO-1:0]            O_top,
  output logic [((NUM_IO*C_BITS) > 0 ? NUM_IO*C_BITS : 1)-1:0] config_C,
  input  logic [FrameBitsPerRow-1:0]   FrameData,
  input  logic [MaxFramesPerCol-1:0]   FrameStrobe,
  output logic [FrameBitsPerRow-1:0]   FrameData_O,
  output logic [MaxFramesPerCol-1:0]   FrameStrobe_O
);

  localparam int CH_BITS    = 4 + C_BITS;
  localparam int USED_BITS  = NUM_IO * CH_BITS;
  localparam int NUM_FRAMES = (USED_BITS + FrameBitsPerRow - 1) / FrameBitsPerRow;
  localparam int CFG_BITS   = NUM_FRAMES * FrameBitsPerRow;

  generate
    if (NUM_FRAMES > MaxFramesPerCol) begin : g_bad_frames
      $error("w_io_bank: configuration needs more frames than MaxFramesPerCol");
    end
  endgenerate

  logic [CFG_BITS-1:0]   cfg;
  logic [NUM_FRAMES-1:0] strb_q;
  logic [NUM_FRAMES-1:0] rise;
  logic [NUM_IO-1:0]     oreg, treg, sync, tinv;
  logic [NUM_IO-1:0]     i_q, t_q, t_eff, s1, s2;

  assign UserCLKo = UserCLK;

  // strb_q resets to ones so a strobe already high at reset release is not an edge
  assign rise = FrameStrobe[NUM_FRAMES-1:0] & ~strb_q;

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      cfg    <= '0;
      strb_q <= '1;
    end else begin
      strb_q <= FrameStrobe[NUM_FRAMES-1:0];
      for (int f = 0; f < NUM_FRAMES; f++) begin
        if (rise[f]) cfg[f*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
      end
    end
  end

  generate
    for (genvar n = 0; n < NUM_IO; n++) begin : g_ch
      localparam int B = n * CH_BITS;
      assign oreg[n] = cfg[B];
      assign treg[n] = cfg[B+1];
      assign sync[n] = cfg[B+2];
      assign tinv[n] = cfg[B+3];
      if (C_BITS > 0) begin : g_taps
        assign config_C[n*C_BITS +: C_BITS] = cfg[B+4 +: C_BITS];
      end
    end
    if (C_BITS == 0) begin : g_no_taps
      assign config_C = 1'b0;
    end
    if (CFG_BITS > USED_BITS) begin : g_spare_bits
      logic unused_cfg;
      assign unused_cfg = ^cfg[CFG_BITS-1:USED_BITS];
    end
  endgenerate

  // Data flops run continuously; config only steers the output muxes.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      i_q <= '0;
      t_q <= '1;
      s1  <= '0;
      s2  <= '0;
    end else begin
      i_q <= I;
      t_q <= t_eff;
      s1  <= O_top;
      s2  <= s1;
    end
  end

  assign t_eff = T ^ tinv;
  assign I_top = (oreg & i_q) | (~oreg & I);
  assign T_top = (treg & t_q) | (~treg & t_eff);
  assign O     = O_top;
  assign Q     = (sync & s2) | (~sync & s1);

  generate
    if (PIPE_FRAME != 0) begin : g_pipe
      logic [FrameBitsPerRow-1:0] data_q;
      logic [MaxFramesPerCol-1:0] strb_fwd_q;
      always_ff @(posedge UserCLK) begin
        if (UserRST) begin
          data_q     <= '0;
          strb_fwd_q <= '0;
        end else begin
          data_q     <= FrameData;
          strb_fwd_q <= FrameStrobe;
        end
      end
      assign FrameData_O   = data_q;
      assign FrameStrobe_O = strb_fwd_q;
    end else begin : g_pass
      assign FrameData_O   = FrameData;
      assign FrameStrobe_O = FrameStrobe;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_w_io_bank.sv
`default_nettype none
// tb_w_io_bank: table-driven and directed checks of the IO bank (NUM_IO=2, C_BITS=4, PIPE_FRAME=1).
module tb_w_io_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        clko;
  logic [1:0]  I, T, O, Q, I_top, T_top, O_top;
  logic [7:0]  cc;
  logic [31:0] fd, fd_o;
  logic [19:0] fs, fs_o;

  int total = 0;
  int bad   = 0;

  w_io_bank #(
    .NUM_IO(2), .C_BITS(4), .FrameBitsPerRow(32), .MaxFramesPerCol(20), .PIPE_FRAME(1)
  ) dut (
    .UserCLK(clk), .UserRST(rst), .UserCLKo(clko),
    .I(I), .T(T), .O(O), .Q(Q), .I_top(I_top), .T_top(T_top), .O_top(O_top),
    .config_C(cc),
    .FrameData(fd), .FrameStrobe(fs), .FrameData_O(fd_o), .FrameStrobe_O(fs_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] fd;
    logic [1:0]  i0, t0, o0, i1, t1, o1;
    logic [1:0]  e_itop, e_ttop, e_o, e_q;
    logic [7:0]  e_cc;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [19:0] strobe, input logic [31:0] data);
    fs = strobe;
    fd = data;
    tick();
    fs = '0;
  endtask

  initial begin
    // Channel byte layout: {taps[3:0], TINV, SYNC, TREG, OREG}, ch0 in bits 7:0, ch1 in 15:8
    vecs[0] = '{16'hF0A5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 8'hFA};
    vecs[1] = '{16'h0F5A, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 8'h05};
    vecs[2] = '{16'h3C03, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 8'h30};
    vecs[3] = '{16'h0000, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 8'h00};

    rst = 1'b1; I = '0; T = '0; O_top = '0;
    fd = 32'hFFFF_FFFF; fs = 20'h00001;
    repeat (2) tick();
    check("fwd_strobe_in_reset", {12'h0, fs_o}, 32'h0);
    check("fwd_data_in_reset", fd_o, 32'h0);
    check("clko_high", {31'h0, clko}, 32'h1);

    // Strobe held high through reset release must not write
    rst = 1'b0;
    repeat (2) tick();
    I = 2'b10; T = 2'b01;
    #2;
    check("rst_cfg_zero", {24'h0, cc}, 32'h0);
    check("rst_itop_pass", {30'h0, I_top}, 32'h2);
    check("rst_ttop_pass", {30'h0, T_top}, 32'h1);
    check("rst_q_zero", {30'h0, Q}, 32'h0);
    #3;
    check("clko_low", {31'h0, clko}, 32'h0);
    fs = '0;
    tick();

    for (int v = 0; v < 4; v++) begin
      write_frame(20'h1, {16'h0, vecs[v].fd});
      I = vecs[v].i0; T = vecs[v].t0; O_top = vecs[v].o0;
      repeat (3) tick();
      I = vecs[v].i1; T = vecs[v].t1; O_top = vecs[v].o1;
      #2;
      check($sformatf("vec%0d_itop", v), {30'h0, I_top}, {30'h0, vecs[v].e_itop});
      check($sformatf("vec%0d_ttop", v), {30'h0, T_top}, {30'h0, vecs[v].e_ttop});
      check($sformatf("vec%0d_o", v), {30'h0, O}, {30'h0, vecs[v].e_o});
      check($sformatf("vec%0d_cc", v), {24'h0, cc}, {24'h0, vecs[v].e_cc});
      tick();
      check($sformatf("vec%0d_q", v), {30'h0, Q}, {30'h0, vecs[v].e_q});
    end

    // Held strobe: only the first cycle's data is captured
    fs = 20'h1; fd = 32'h0000_5040;
    tick();
    check("held_first", {24'h0, cc}, 32'h54);
    for (int k = 0; k < 4; k++) begin
      fd = 32'h0000_A0B0 + 32'(k * 16'h1111);
      tick();
    end
    fs = '0;
    tick();
    check("held_once", {24'h0, cc}, 32'h54);

    // ch1 SYNC=1: two-edge latency, O combinational
    write_frame(20'h1, 32'h0000_0400);
    O_top = 2'b00;
    repeat (3) tick();
    O_top = 2'b10;
    #2;
    check("sync_o_comb", {30'h0, O}, 32'h2);
    check("sync_q_pre", {30'h0, Q}, 32'h0);
    tick();
    check("sync_q_edge_k", {30'h0, Q}, 32'h0);
    tick();
    check("sync_q_edge_k1", {30'h0, Q}, 32'h2);
    write_frame(20'h1, 32'h0);
    O_top = 2'b00;
    repeat (3) tick();
    O_top = 2'b10;
    tick();
    check("nosync_q_edge_k", {30'h0, Q}, 32'h2);

    // Strobes 0 and 5 together; frame 5 does not exist
    fs = 20'h00021; fd = 32'h0000_3355;
    #2;
    check("fwd_strobe_pre", {12'h0, fs_o}, 32'h0);
    tick();
    check("fwd_strobe_lag", {12'h0, fs_o}, 32'h21);
    check("fwd_data_lag", fd_o, 32'h3355);
    check("multi_cfg", {24'h0, cc}, 32'h35);
    fs = '0;
    tick();
    check("fwd_strobe_clear", {12'h0, fs_o}, 32'h0);

    // OREG on ch0: one-cycle lag
    write_frame(20'h1, 32'h0000_0001);
    I = 2'b00;
    repeat (2) tick();
    I = 2'b01;
    #2;
    check("oreg_pre", {30'h0, I_top}, 32'h0);
    tick();
    check("oreg_post", {30'h0, I_top}, 32'h1);

    // Reset mid-operation after full config
    write_frame(20'h1, 32'h0000_FFFF);
    I = 2'b01; T = 2'b10; O_top = 2'b11;
    repeat (3) tick();
    check("full_cfg", {24'h0, cc}, 32'hFF);
    rst = 1'b1;
    tick();
    check("mid_rst_cfg", {24'h0, cc}, 32'h0);
    check("mid_rst_itop", {30'h0, I_top}, 32'h1);
    check("mid_rst_ttop", {30'h0, T_top}, 32'h2);
    check("mid_rst_q", {30'h0, Q}, 32'h0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
